// File: rtl/game_pkg.sv
// Shared types and defaults for the Frogger game sequencer.
// Holds the game state enum, sprite/goal defaults and the box-overlap helper.
package game_pkg;

  localparam int POS_W       = 10;
  localparam int FROG_W_DEF  = 32;
  localparam int FROG_H_DEF  = 32;
  localparam int CAR_W_DEF   = 64;
  localparam int CAR_H_DEF   = 32;
  localparam int GOAL_Y_DEF  = 32;
  localparam int START_LIVES_DEF = 3;
  localparam int MAX_LEVEL_DEF   = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_HIT,
    ST_SCORE,
    ST_OVER
  } game_state_t;

  // Operands are one bit wider than a position so x+W never wraps.
  function automatic logic boxes_overlap(
    input logic [POS_W:0] fx,
    input logic [POS_W:0] fy,
    input logic [POS_W:0] cx,
    input logic [POS_W:0] cy,
    input logic [POS_W:0] fw,
    input logic [POS_W:0] fh,
    input logic [POS_W:0] cw,
    input logic [POS_W:0] ch
  );
    return (fx < cx + cw) && (cx < fx + fw) && (fy < cy + ch) && (cy < fy + fh);
  endfunction

endpackage

// File: rtl/collision_scanner.sv
// Per-frame collision scanner: snapshots frog and car positions on launch, then
// checks one car per cycle and reports accumulated hit and goal flags with done.
module collision_scanner
  import game_pkg::*;
#(
  parameter int NUM_CARS = 10,
  parameter int FROG_W   = FROG_W_DEF,
  parameter int FROG_H   = FROG_H_DEF,
  parameter int CAR_W    = CAR_W_DEF,
  parameter int CAR_H    = CAR_H_DEF,
  parameter int GOAL_Y   = GOAL_Y_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      launch,
  input  logic [POS_W-1:0]          frog_x,
  input  logic [POS_W-1:0]          frog_y,
  input  logic [POS_W*NUM_CARS-1:0] car_x_flat,
  input  logic [POS_W*NUM_CARS-1:0] car_y_flat,
  output logic                      done,
  output logic                      hit,
  output logic                      goal
);

  localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

  logic [POS_W-1:0] frog_x_snap_reg;
  logic [POS_W-1:0] frog_y_snap_reg;
  logic [POS_W-1:0] car_x_snap_reg [NUM_CARS];
  logic [POS_W-1:0] car_y_snap_reg [NUM_CARS];
  logic [IDX_W-1:0] idx_reg;
  logic             busy_reg;
  logic             hit_acc_reg;
  logic             done_reg;
  logic             hit_reg;
  logic             goal_reg;

  logic             start_scan;
  logic             car_hit;
  logic             last_car;

  // A launch while a scan is running is dropped, so the snapshot stays intact.
  assign start_scan = launch && !busy_reg;
  assign last_car   = (idx_reg == IDX_W'(NUM_CARS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      frog_x_snap_reg <= '0;
      frog_y_snap_reg <= '0;
    end else if (start_scan) begin
      frog_x_snap_reg <= frog_x;
      frog_y_snap_reg <= frog_y;
    end
  end

  for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_car_snap
    always_ff @(posedge clk) begin
      if (reset) begin
        car_x_snap_reg[gi] <= '0;
        car_y_snap_reg[gi] <= '0;
      end else if (start_scan) begin
        car_x_snap_reg[gi] <= car_x_flat[POS_W*gi +: POS_W];
        car_y_snap_reg[gi] <= car_y_flat[POS_W*gi +: POS_W];
      end
    end
  end

  assign car_hit = boxes_overlap({1'b0, frog_x_snap_reg}, {1'b0, frog_y_snap_reg},
                                 {1'b0, car_x_snap_reg[idx_reg]}, {1'b0, car_y_snap_reg[idx_reg]},
                                 (POS_W+1)'(FROG_W), (POS_W+1)'(FROG_H),
                                 (POS_W+1)'(CAR_W), (POS_W+1)'(CAR_H));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg    <= 1'b0;
      idx_reg     <= '0;
      hit_acc_reg <= 1'b0;
      done_reg    <= 1'b0;
      hit_reg     <= 1'b0;
      goal_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start_scan) begin
        busy_reg    <= 1'b1;
        idx_reg     <= '0;
        hit_acc_reg <= 1'b0;
      end else if (busy_reg) begin
        hit_acc_reg <= hit_acc_reg | car_hit;
        if (last_car) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
          hit_reg  <= hit_acc_reg | car_hit;
          goal_reg <= ({1'b0, frog_y_snap_reg} <= (POS_W+1)'(GOAL_Y));
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end
    end
  end

  assign done = done_reg;
  assign hit  = hit_reg;
  assign goal = goal_reg;

endmodule

// File: rtl/game_controller.sv
// Frogger game sequencer: per-frame collision/goal scan, lives/score/level and
// respawn/car controls. Define GAME_INVINCIBLE_EN to make hits non-fatal.
module game_controller
  import game_pkg::*;
#(
  parameter int NUM_CARS    = 10,
  parameter int FROG_W      = FROG_W_DEF,
  parameter int FROG_H      = FROG_H_DEF,
  parameter int CAR_W       = CAR_W_DEF,
  parameter int CAR_H       = CAR_H_DEF,
  parameter int GOAL_Y      = GOAL_Y_DEF,
  parameter int START_LIVES = START_LIVES_DEF,
  parameter int HIT_FRAMES  = 60,
  parameter int MAX_LEVEL   = MAX_LEVEL_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic                      start,
  input  logic [POS_W-1:0]          frog_x,
  input  logic [POS_W-1:0]          frog_y,
  input  logic [POS_W*NUM_CARS-1:0] car_x_flat,
  input  logic [POS_W*NUM_CARS-1:0] car_y_flat,
  output logic                      frog_respawn,
  output logic                      cars_run,
  output logic [2:0]                car_speed,
  output logic [1:0]                lives,
  output logic [7:0]                score,
  output logic                      game_over
);

  localparam int HC_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

  game_state_t     state_reg, state_next;
  logic [1:0]      lives_reg, lives_next;
  logic [7:0]      score_reg, score_next;
  logic [2:0]      level_reg, level_next;
  logic [HC_W-1:0] hit_cnt_reg, hit_cnt_next;
  logic            start_prev_reg;

  logic start_rise;
  logic scan_done;
  logic scan_hit;
  logic scan_goal;
  logic hit_taken;

  assign start_rise = start && !start_prev_reg;

  collision_scanner #(
    .NUM_CARS (NUM_CARS),
    .FROG_W   (FROG_W),
    .FROG_H   (FROG_H),
    .CAR_W    (CAR_W),
    .CAR_H    (CAR_H),
    .GOAL_Y   (GOAL_Y)
  ) u_scanner (
    .clk        (clk),
    .reset      (reset),
    .launch     (frame_tick && (state_reg == ST_PLAY)),
    .frog_x     (frog_x),
    .frog_y     (frog_y),
    .car_x_flat (car_x_flat),
    .car_y_flat (car_y_flat),
    .done       (scan_done),
    .hit        (scan_hit),
    .goal       (scan_goal)
  );

`ifdef GAME_INVINCIBLE_EN
  assign hit_taken = 1'b0;
`else
  assign hit_taken = scan_hit;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      lives_reg      <= 2'(START_LIVES);
      score_reg      <= '0;
      level_reg      <= '0;
      hit_cnt_reg    <= '0;
      // Primed from the live input so a start held through reset is not an edge.
      start_prev_reg <= start;
    end else begin
      state_reg      <= state_next;
      lives_reg      <= lives_next;
      score_reg      <= score_next;
      level_reg      <= level_next;
      hit_cnt_reg    <= hit_cnt_next;
      start_prev_reg <= start;
    end
  end

  always_comb begin
    state_next   = state_reg;
    lives_next   = lives_reg;
    score_next   = score_reg;
    level_next   = level_reg;
    hit_cnt_next = hit_cnt_reg;
    frog_respawn = 1'b0;
    cars_run     = 1'b0;
    game_over    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start_rise) begin
          state_next = ST_PLAY;
          lives_next = 2'(START_LIVES);
          score_next = '0;
          level_next = '0;
        end
      end
      ST_PLAY: begin
        cars_run = 1'b1;
        if (scan_done) begin
          if (hit_taken) begin
            state_next   = ST_HIT;
            lives_next   = lives_reg - 2'd1;
            hit_cnt_next = '0;
          end else if (scan_goal) begin
            state_next = ST_SCORE;
            score_next = (score_reg == 8'hFF) ? score_reg : score_reg + 8'd1;
            level_next = (level_reg == 3'(MAX_LEVEL)) ? level_reg : level_reg + 3'd1;
          end
        end
      end
      ST_HIT: begin
        if (lives_reg == 2'd0) begin
          state_next = ST_OVER;
        end else if (frame_tick) begin
          if (hit_cnt_reg == HC_W'(HIT_FRAMES - 1)) begin
            frog_respawn = 1'b1;
            state_next   = ST_PLAY;
          end else begin
            hit_cnt_next = hit_cnt_reg + 1'b1;
          end
        end
      end
      ST_SCORE: begin
        cars_run     = 1'b1;
        frog_respawn = 1'b1;
        state_next   = ST_PLAY;
      end
      ST_OVER: begin
        game_over = 1'b1;
        if (start_rise) begin
          state_next = ST_PLAY;
          lives_next = 2'(START_LIVES);
          score_next = '0;
          level_next = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign lives     = lives_reg;
  assign score     = score_reg;
  assign car_speed = level_reg;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: reset, scan latency, hits, scoring,
// overlap boundaries, dropped re-ticks and game-over restart.
module tb_game_controller;

  localparam int NC = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_tick;
  logic          start;
  logic [9:0]    frog_x, frog_y;
  logic [10*NC-1:0] car_x_flat, car_y_flat;
  logic          frog_respawn, cars_run, game_over;
  logic [2:0]    car_speed;
  logic [1:0]    lives;
  logic [7:0]    score;

  int checks = 0;
  int errors = 0;

  game_controller dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .frog_x       (frog_x),
    .frog_y       (frog_y),
    .car_x_flat   (car_x_flat),
    .car_y_flat   (car_y_flat),
    .frog_respawn (frog_respawn),
    .cars_run     (cars_run),
    .car_speed    (car_speed),
    .lives        (lives),
    .score        (score),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end else begin
      $display("ok   %s = %0d", tag, actual);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic set_car(input int i, input int x, input int y);
    car_x_flat[10*i +: 10] = 10'(x);
    car_y_flat[10*i +: 10] = 10'(y);
  endtask

  // Feed HIT_FRAMES ticks; respawn must appear only on the last one.
  task automatic hit_recover(input string tag);
    for (int k = 1; k <= 60; k++) begin
      frame_tick = 1'b1;
      #1;
      if (k == 59) check_val({tag, "_respawn_k59"}, 32'(frog_respawn), 32'd0);
      if (k == 60) check_val({tag, "_respawn_k60"}, 32'(frog_respawn), 32'd1);
      step();
      frame_tick = 1'b0;
      step();
    end
    check_val({tag, "_back_in_play"}, 32'(cars_run), 32'd1);
    check_val({tag, "_respawn_low"}, 32'(frog_respawn), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    frame_tick = 1'b0;
    frog_x = 10'd300;
    frog_y = 10'd400;
    for (int i = 0; i < NC; i++) set_car(i, 700, 100);
    repeat (3) step();
    reset = 1'b0;
    check_val("rst_cars_run", 32'(cars_run), 32'd0);
    check_val("rst_lives", 32'(lives), 32'd3);
    check_val("rst_score", 32'(score), 32'd0);
    check_val("rst_car_speed", 32'(car_speed), 32'd0);
    check_val("rst_game_over", 32'(game_over), 32'd0);
    check_val("rst_respawn", 32'(frog_respawn), 32'd0);
    repeat (3) step();
    check_val("held_start_no_play", 32'(cars_run), 32'd0);

    start = 1'b0;
    step();
    start = 1'b1;
    step();
    check_val("start_play", 32'(cars_run), 32'd1);
    check_val("start_lives", 32'(lives), 32'd3);

    set_car(4, 280, 192);
    pulse_tick();
    repeat (11) step();
    check_val("car4_clear_run", 32'(cars_run), 32'd1);
    check_val("car4_clear_lives", 32'(lives), 32'd3);

    set_car(4, 290, 400);
    pulse_tick();
    repeat (10) step();
    check_val("hit_t11_still_play", 32'(cars_run), 32'd1);
    step();
    check_val("hit_t12_cars_run", 32'(cars_run), 32'd0);
    check_val("hit_t12_lives", 32'(lives), 32'd2);
    set_car(4, 700, 100);
    hit_recover("hit1");

    frog_y = 10'd32;
    pulse_tick();
    repeat (11) step();
    check_val("score_respawn", 32'(frog_respawn), 32'd1);
    check_val("score_value", 32'(score), 32'd1);
    check_val("score_speed", 32'(car_speed), 32'd1);
    step();
    check_val("score_respawn_done", 32'(frog_respawn), 32'd0);
    check_val("score_back_play", 32'(cars_run), 32'd1);

    frog_y = 10'd33;
    pulse_tick();
    repeat (12) step();
    check_val("goal_y33_no_score", 32'(score), 32'd1);

    // Second tick at T+3 carries a goal position; it must be dropped.
    frog_y = 10'd400;
    pulse_tick();
    step();
    step();
    frog_y = 10'd32;
    pulse_tick();
    frog_y = 10'd400;
    repeat (8) step();
    check_val("retick_t12_score", 32'(score), 32'd1);
    repeat (3) step();
    check_val("retick_t15_score", 32'(score), 32'd1);
    check_val("retick_t15_respawn", 32'(frog_respawn), 32'd0);

    frog_y = 10'd32;
    set_car(0, 300, 32);
    pulse_tick();
    repeat (11) step();
    check_val("hit_goal_lives", 32'(lives), 32'd1);
    check_val("hit_goal_score", 32'(score), 32'd1);
    check_val("hit_goal_cars_run", 32'(cars_run), 32'd0);
    frog_y = 10'd400;
    set_car(0, 700, 100);
    hit_recover("hit2");

    frog_x = 10'd364;
    set_car(0, 300, 400);
    pulse_tick();
    repeat (12) step();
    check_val("edge_fx_eq_cx_w_lives", 32'(lives), 32'd1);
    check_val("edge_fx_eq_cx_w_run", 32'(cars_run), 32'd1);

    frog_x = 10'd0;
    set_car(0, 1023, 400);
    pulse_tick();
    repeat (12) step();
    check_val("wrap_no_hit_lives", 32'(lives), 32'd1);

    frog_x = 10'd363;
    set_car(0, 300, 400);
    pulse_tick();
    repeat (11) step();
    check_val("hit3_lives", 32'(lives), 32'd0);
    check_val("hit3_cars_run", 32'(cars_run), 32'd0);
    step();
    check_val("over_game_over", 32'(game_over), 32'd1);
    set_car(0, 700, 100);
    frog_x = 10'd300;

    start = 1'b0;
    step();
    start = 1'b1;
    step();
    check_val("restart_game_over", 32'(game_over), 32'd0);
    check_val("restart_cars_run", 32'(cars_run), 32'd1);
    check_val("restart_lives", 32'(lives), 32'd3);
    check_val("restart_score", 32'(score), 32'd0);
    check_val("restart_speed", 32'(car_speed), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
